// File: rtl/fifo_rd_serializer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fifo_rd_serializer
//
// Pops FIFO_WIDTH-bit words from a first-word-fall-through sync FIFO and emits
// them as R = FIFO_WIDTH/OUT_WIDTH chunks of OUT_WIDTH bits, LSB chunk first,
// on a valid/ready stream. The next word is popped in the same cycle as the
// final chunk's handshake, so a full FIFO sustains one chunk per cycle.
//
// Ports
//   clk_i          clock, rising edge
//   resetn_i       asynchronous active-low reset
//   fifo_rempty_i  upstream FIFO empty flag
//   fifo_rdata_i   upstream FIFO head word (valid while fifo_rempty_i = 0)
//   fifo_rd_en_o   combinational pop strobe; head consumed on the edge
//   flush_i        synchronous discard of the held word
//   out_valid_o    chunk valid
//   out_ready_i    downstream ready
//   out_data_o     current chunk
//   out_last_o     current chunk is the final chunk of its word
//   busy_o         a word is held
// -----------------------------------------------------------------------------
module fifo_rd_serializer #(
    parameter int FIFO_WIDTH = 64,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  fifo_rempty_i,
    input  logic [FIFO_WIDTH-1:0] fifo_rdata_i,
    output logic                  fifo_rd_en_o,
    input  logic                  flush_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [OUT_WIDTH-1:0]  out_data_o,
    output logic                  out_last_o,
    output logic                  busy_o
);

    localparam int RATIO = FIFO_WIDTH / OUT_WIDTH;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

    // Reject ratios that are not a power of two >= 2 at elaboration.
    if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0 || (FIFO_WIDTH % OUT_WIDTH) != 0) begin : g_illegal_ratio
        $error("fifo_rd_serializer: FIFO_WIDTH/OUT_WIDTH must be a power of two >= 2");
    end

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [FIFO_WIDTH-1:0] word_q,  word_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;

    logic handshake;
    logic at_last;
    logic pop;

    // Word viewed as an array of chunks so the chunk select is a plain index.
    logic [RATIO-1:0][OUT_WIDTH-1:0] word_chunks;
    assign word_chunks = word_q;

    assign handshake = (state_q == ST_SHIFT) && out_ready_i;
    assign at_last   = (cnt_q == CNT_LAST);

    // Pop when idle, or back-to-back on the final chunk's handshake. Flush and
    // reset both veto the pop; reset is included because state alone reads
    // EMPTY while resetn_i is low and would otherwise strobe a non-empty FIFO.
    assign pop = resetn_i && !flush_i && !fifo_rempty_i &&
                 ((state_q == ST_EMPTY) || (handshake && at_last));

    // State register
    // NOTE: the word register is reset along with the control state because
    // out_data_o must read zero during reset; it is one register, not a RAM.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= ST_EMPTY;
            word_q  <= '0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: hold-by-default assignments first, so no path leaves a _d
        // signal unassigned and no latch is inferred.
        state_d = state_q;
        word_d  = word_q;
        cnt_d   = cnt_q;

        if (flush_i) begin
            // Flush wins over any handshake or pop in the same cycle.
            state_d = ST_EMPTY;
            cnt_d   = '0;
        end else if (pop) begin
            word_d  = fifo_rdata_i;
            cnt_d   = '0;
            state_d = ST_SHIFT;
        end else if (handshake) begin
            if (at_last) begin
                state_d = ST_EMPTY;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Output logic
    always_comb begin
        fifo_rd_en_o = pop;
        out_valid_o  = (state_q == ST_SHIFT);
        busy_o       = (state_q == ST_SHIFT);
        out_last_o   = (state_q == ST_SHIFT) && at_last;
        out_data_o   = word_chunks[cnt_q];
    end

endmodule

// File: tb/tb_fifo_rd_serializer.sv
`timescale 1ns/1ps
// Scoreboard bench for fifo_rd_serializer: stimulus pushes words into a FIFO
// model and the chunks it expects into exp_q; a monitor compares every
// handshake against exp_q and polices pop/stall protocol rules.
module tb_fifo_rd_serializer;

    localparam int FW = 64;
    localparam int OW = 16;
    localparam int R  = FW / OW;

    logic          clk = 1'b0;
    logic          resetn;
    logic          rempty;
    logic [FW-1:0] rdata;
    logic          rd_en;
    logic          flush;
    logic          valid;
    logic          ready;
    logic [OW-1:0] data;
    logic          last;
    logic          busy;

    always #5 clk = ~clk;

    fifo_rd_serializer #(.FIFO_WIDTH(FW), .OUT_WIDTH(OW)) dut (
        .clk_i        (clk),
        .resetn_i     (resetn),
        .fifo_rempty_i(rempty),
        .fifo_rdata_i (rdata),
        .fifo_rd_en_o (rd_en),
        .flush_i      (flush),
        .out_valid_o  (valid),
        .out_ready_i  (ready),
        .out_data_o   (data),
        .out_last_o   (last),
        .busy_o       (busy)
    );

    typedef struct packed {
        logic [OW-1:0] data;
        logic          last;
    } chunk_t;

    chunk_t        exp_q[$];
    logic [FW-1:0] fq[$];
    chunk_t        exp_c;

    int tests = 0;
    int fails = 0;
    int pops = 0;
    int valid_cycles = 0;
    int streak = 0;
    int max_streak = 0;
    int viol = 0;
    int base_pops;
    int base_valid;

    logic          pop_pending = 1'b0;
    logic          prev_pop    = 1'b0;
    logic          prev_stall  = 1'b0;
    logic [OW-1:0] prev_data   = '0;
    logic          prev_last   = 1'b0;
    logic [15:0]   ready_pat   = 16'b0101_0011_0110_1001;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic refresh_head();
        rempty = (fq.size() == 0);
        rdata  = (fq.size() != 0) ? fq[0] : '0;
    endtask

    // Queue a word in the FIFO model and expect its first nkeep chunks.
    task automatic push_word(input logic [FW-1:0] w, input int nkeep);
        chunk_t c;
        fq.push_back(w);
        for (int i = 0; i < nkeep; i++) begin
            c.data = w[i*OW +: OW];
            c.last = (i == R - 1);
            exp_q.push_back(c);
        end
        refresh_head();
    endtask

    // Bounded wait until chunk v is presented; lands 2 time units after a negedge.
    task automatic wait_chunk(input logic [OW-1:0] v, input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            #2;
            if (valid === 1'b1 && data === v) found = 1'b1;
        end
        check(name, found, 1'b1);
    endtask

    // FIFO model: consume the head on the edge where a pop was seen.
    always @(posedge clk) begin
        #1;
        if (pop_pending) begin
            if (fq.size() > 0) void'(fq.pop_front());
            pop_pending = 1'b0;
        end
        refresh_head();
    end

    // Monitor: samples 3 time units after each negedge, well clear of posedge.
    always begin
        @(negedge clk);
        #3;
        if (resetn !== 1'b1) begin
            prev_pop    = 1'b0;
            prev_stall  = 1'b0;
            pop_pending = 1'b0;
            streak      = 0;
        end else begin
            if (rd_en && rempty) viol++;
            if (rd_en && flush)  viol++;
            if (prev_pop) check("valid_after_pop", valid, 1'b1);
            if (valid) begin
                valid_cycles++;
                streak++;
                if (streak > max_streak) max_streak = streak;
            end else begin
                streak = 0;
            end
            if (valid && prev_stall) begin
                check("stall_data", data, prev_data);
                check("stall_last", last, prev_last);
            end
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_chunk: got 0x%0h, want none", data);
                end else begin
                    exp_c = exp_q.pop_front();
                    check("chunk_data", data, exp_c.data);
                    check("chunk_last", last, exp_c.last);
                end
            end
            prev_stall  = valid && !ready && !flush;
            prev_data   = data;
            prev_last   = last;
            prev_pop    = rd_en;
            pop_pending = rd_en;
            if (rd_en) pops++;
        end
    end

    initial begin
        resetn = 1'b0;
        flush  = 1'b0;
        ready  = 1'b0;
        refresh_head();

        // Reset state
        #2;
        check("rst_valid", valid, 1'b0);
        check("rst_busy",  busy,  1'b0);
        check("rst_last",  last,  1'b0);
        check("rst_data",  data,  16'h0);
        push_word(64'h4444_3333_2222_1111, 4);
        #1;
        check("rst_rd_en_nonempty", rd_en, 1'b0);

        // Single word, ready held high
        @(negedge clk);
        ready = 1'b1;
        #1 resetn = 1'b1;
        repeat (8) @(negedge clk);
        check("t1_pops", pops, 1);
        check("t1_valid_idle", valid, 1'b0);
        check("t1_busy_idle", busy, 1'b0);

        // Back-to-back: three words, no bubbles
        base_pops  = pops;
        base_valid = valid_cycles;
        max_streak = 0;
        push_word(64'hA003_A002_A001_A000, 4);
        push_word(64'hB003_B002_B001_B000, 4);
        push_word(64'hC003_C002_C001_C000, 4);
        repeat (16) @(negedge clk);
        check("t2_pops", pops - base_pops, 3);
        check("t2_valid_cycles", valid_cycles - base_valid, 12);
        check("t2_streak", max_streak, 12);

        // Backpressure with a fixed ready pattern
        base_pops = pops;
        push_word(64'hD003_D002_D001_D000, 4);
        push_word(64'hE003_E002_E001_E000, 4);
        for (int i = 0; i < 80 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            ready = ready_pat[i % 16];
        end
        check("t3_drained", exp_q.size(), 0);
        check("t3_pops", pops - base_pops, 2);
        @(negedge clk);
        ready = 1'b1;
        repeat (3) @(negedge clk);

        // Empty boundary: final chunk with nothing queued behind it
        base_pops = pops;
        push_word(64'hF003_F002_F001_F000, 4);
        wait_chunk(16'hF003, "t4_final_chunk");
        #1;
        check("t4_rd_en_on_last", rd_en, 1'b0);
        @(negedge clk);
        #1;
        check("t4_valid_after", valid, 1'b0);
        check("t4_busy_after", busy, 1'b0);
        check("t4_pops", pops - base_pops, 1);

        // Flush at cnt=1, then flush on a last chunk with a word waiting
        base_pops = pops;
        push_word(64'h5503_5502_5501_5500, 2);
        push_word(64'h6603_6602_6601_6600, 4);
        push_word(64'h7703_7702_7701_7700, 4);
        wait_chunk(16'h5501, "t5_reach_cnt1");
        flush = 1'b1;
        #1;
        check("t5_rd_en_flush_mid", rd_en, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("t5_valid_after_flush_mid", valid, 1'b0);
        wait_chunk(16'h6603, "t5_reach_last");
        flush = 1'b1;
        #1;
        check("t5_rd_en_flush_last", rd_en, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("t5_valid_after_flush_last", valid, 1'b0);
        repeat (8) @(negedge clk);
        check("t5_pops", pops - base_pops, 3);

        // Asynchronous reset at cnt=2
        base_pops = pops;
        push_word(64'h8803_8802_8801_8800, 2);
        push_word(64'h9903_9902_9901_9900, 4);
        wait_chunk(16'h8802, "t6_reach_cnt2");
        resetn = 1'b0;
        #1;
        check("t6_valid_in_reset", valid, 1'b0);
        check("t6_busy_in_reset", busy, 1'b0);
        check("t6_rd_en_in_reset", rd_en, 1'b0);
        check("t6_data_in_reset", data, 16'h0);
        @(negedge clk);
        #1 resetn = 1'b1;
        repeat (8) @(negedge clk);
        check("t6_pops", pops - base_pops, 2);

        // Global end-of-run checks
        check("all_chunks_seen", exp_q.size(), 0);
        check("fifo_drained", fq.size(), 0);
        check("rd_en_protocol_violations", viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
